// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// iteration counter width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One spare bit so the counter can hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_adder.sv
// One-bit full adder cell shared by the team's datapaths; purely combinational.
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum2,
  output logic cout
);

  assign sum2 = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
  logic             c_msb_r;
`endif

  adder fa0 (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum2 (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Control FSM with registered status outputs, plus the serial datapath it sequences.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      c_msb_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r  <= S_SHIFT;
            busy_r   <= 1'b1;
            a_sh_r   <= a;
            b_sh_r   <= b;
            carry_r  <= cin;
            sum_sh_r <= '0;
            cnt_r    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            c_msb_r  <= 1'b0;
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          sum_sh_r <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
          carry_r  <= fa_cout_s;
          cnt_r    <= cnt_r + CNT_ONE;
          // The MSB is being summed on this edge: the old carry is the carry into it.
          if (cnt_r == CNT_LAST) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            c_msb_r <= carry_r;
`endif
          end else begin
            done_r <= 1'b0;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_sh_r;
  assign cout = carry_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = c_msb_r ^ carry_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, scoreboard queue and
// hand-written sequences for ignored start, mid-operation reset and back-to-back use.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start, pushes the expectation, then scrambles the operands.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic [W-1:0] es, input logic ec);
    exp_t e;
    e.sum  = es;
    e.cout = ec;
    e.ovf  = (va[W-1] == vb[W-1]) && (es[W-1] != va[W-1]);
    sb_q.push_back(e);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 4 * W) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
    if (busy) busy_n++;
    chk({tag, " done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    chk({tag, " sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " sum"}, 32'(sum), 32'(e.sum));
      chk({tag, " cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
      chk({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    end
  endtask

  initial begin
    int lat;
    int busy_n;
    int nd;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset ovf", 32'(ovf), 32'd0);
`endif

    // Reset must win over a simultaneous start.
    start = 1'b1;
    a     = 8'h11;
    tick();
    chk("reset beats start busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
      wait_done($sformatf("vec%0d", i), lat, busy_n);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(W));
      chk($sformatf("vec%0d busy_cycles", i), 32'(busy_n), 32'(W + 1));
      compare_result($sformatf("vec%0d", i));
      tick();
      chk($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d busy_after", i), 32'(busy), 32'd0);
      chk($sformatf("vec%0d sum_held", i), 32'(sum), 32'(vecs[i].sum));
      tick();
    end

    // A start during SHIFT with fresh operands must be ignored.
    issue(8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    tick();
    tick();
    a     = 8'hF0;
    b     = 8'h0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ignored", lat, busy_n);
    compare_result("ignored");
    nd = 0;
    repeat (2 * W) begin
      tick();
      if (done) nd++;
    end
    chk("ignored extra_done", 32'(nd), 32'd0);
    chk("ignored sum_held", 32'(sum), 32'h08);

    // Reset pulse in the middle of an operation discards it.
    issue(8'hAA, 8'h11, 1'b0, 8'hBB, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb_q.pop_back());
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst sum", 32'(sum), 32'd0);
    chk("midrst cout", 32'(cout), 32'd0);
    nd = 0;
    repeat (W + 3) begin
      tick();
      if (done) nd++;
    end
    chk("midrst no_done", 32'(nd), 32'd0);
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    wait_done("after_rst", lat, busy_n);
    chk("after_rst latency", 32'(lat), 32'(W));
    compare_result("after_rst");
    tick();

    // Back-to-back: restart in the first IDLE cycle after done.
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    wait_done("b2b_first", lat, busy_n);
    compare_result("b2b_first");
    tick();
    chk("b2b first_held", 32'(sum), 32'h46);
    issue(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0);
    chk("b2b accepted busy", 32'(busy), 32'd1);
    chk("b2b sum_cleared", 32'(sum), 32'd0);
    wait_done("b2b_second", lat, busy_n);
    chk("b2b_second latency", 32'(lat), 32'(W));
    compare_result("b2b_second");
    tick();

    chk("sb drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
